phoneme_sequencer: RTL and testbench

Plays stored phrases by sending a sequence of 6-bit phoneme codes to the `chatter` speech block, acting as the writer side of its `data`/`write`/`busy` handshake. Phrase entries are fetched from an external synchronous code ROM. Each entry is offered to `chatter` only when it is idle, and a phrase ends on an end-of-phrase flag, a length limit, or an abort. The block sits between control logic (buttons, UART command decoder) and `chatter`.

---
 rtl/phoneme_sequencer.sv | 135 +++++++++++++
 tb/tb_phoneme_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phoneme_sequencer.sv
`timescale 1ns / 1ps
// Phrase player: walks a code ROM and hands each phoneme to the chatter
// speech block over its data/write/busy handshake.
module phoneme_sequencer #(
  parameter int MAX_LEN    = 64,
  parameter int BUSY_GUARD = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] start_addr,
  input  logic       abort,
  output logic [7:0] rom_addr,
  input  logic [6:0] rom_data,
  input  logic       busy,
  output logic [5:0] data,
  output logic       write,
  output logic       active,
  output logic       done
);

  localparam int GW = (BUSY_GUARD > 1) ? $clog2(BUSY_GUARD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_WAIT_IDLE,
    S_WRITE,
    S_GUARD
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [5:0]    code_q, code_d;
  logic          last_q, last_d;
  logic [5:0]    data_q, data_d;
  logic          abort_q, abort_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          done_q, done_d;

  logic guard_end;
  logic phrase_end;

  assign guard_end  = (guard_q == GW'(BUSY_GUARD - 1));
  assign phrase_end = last_q || (cnt_q == 7'(MAX_LEN)) || abort_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    last_d  = last_q;
    data_d  = data_q;
    guard_d = guard_q;
    done_d  = 1'b0;
    abort_d = abort_q | (abort && (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        code_d  = rom_data[5:0];
        last_d  = rom_data[6];
        state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (abort_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (!busy) begin
          data_d  = code_q;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 7'd1;
        guard_d = '0;
        state_d = S_GUARD;
      end
      S_GUARD: begin
        // busy from chatter is not trusted until the guard has run out
        if (!guard_end) begin
          guard_d = guard_q + GW'(1);
        end else if (phrase_end) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      abort_q <= 1'b0;
      guard_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      last_q  <= last_d;
      data_q  <= data_d;
      abort_q <= abort_d;
      guard_q <= guard_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign data     = data_q;
  assign write    = (state_q == S_WRITE);
  assign active   = (state_q != S_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_phoneme_sequencer.sv
`timescale 1ns / 1ps
// Bench for phoneme_sequencer: ROM and chatter models, phrase table,
// randomized phrases against a list-walking reference model.
module tb_phoneme_sequencer;

  localparam int MAX_LEN    = 64;
  localparam int BUSY_GUARD = 3;
  localparam int SPACING    = BUSY_GUARD + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] start_addr = 8'h00;
  logic       abort = 1'b0;
  logic [7:0] rom_addr;
  logic [6:0] rom_data = 7'h00;
  logic       busy;
  logic [5:0] data;
  logic       write;
  logic       active;
  logic       done;

  logic chat_busy = 1'b0;
  logic force_busy = 1'b0;
  bit   chat_en = 1'b0;
  int   lmin = 2;
  int   lmax = 50;

  assign busy = chat_busy | force_busy;

  phoneme_sequencer #(
    .MAX_LEN   (MAX_LEN),
    .BUSY_GUARD(BUSY_GUARD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .abort     (abort),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy),
    .data      (data),
    .write     (write),
    .active    (active),
    .done      (done)
  );

  initial forever #5 clk = ~clk;

  logic [6:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic [5:0] code;
    logic       busy;
    int         cyc;
  } wr_t;

  wr_t wlog[$];
  int  ndone = 0;
  int  cyc = 0;

  // write/done observer; main process only reads what it records
  initial forever begin
    wr_t w;
    @(negedge clk);
    cyc = cyc + 1;
    if (write === 1'b1) begin
      w.code = data;
      w.busy = busy;
      w.cyc  = cyc;
      wlog.push_back(w);
    end
    if (done === 1'b1) ndone = ndone + 1;
  end

  // chatter: busy rises within the guard window, stays high a while
  initial forever begin
    @(negedge clk);
    if (chat_en && write === 1'b1) begin
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1 chat_busy = 1'b1;
      repeat ($urandom_range(lmin, lmax)) @(posedge clk);
      #1 chat_busy = 1'b0;
    end
  end

  initial begin
    #1500us;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] a);
    start      = 1'b1;
    start_addr = a;
    tick();
    start      = 1'b0;
  endtask

  // reference: follow the ROM list until last flag or length limit
  function automatic void model(input logic [7:0] sa);
    logic [7:0] a;
    logic [6:0] w;
    a = sa;
    exp_q.delete();
    for (int n = 0; n < MAX_LEN; n++) begin
      w = rom[a];
      exp_q.push_back(w[5:0]);
      if (w[6]) break;
      a = a + 8'd1;
    end
  endfunction

  task automatic run_check(input string nm, input logic [7:0] sa,
                           output int base);
    int  d0;
    bit  ok;
    base = wlog.size();
    d0   = ndone;
    pulse_start(sa);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({nm, " done_seen"}, 32'(ok), 32'd1);
    tick();
    tick();
    chk({nm, " active_after"}, 32'(active), 32'd0);
    chk({nm, " done_count"}, 32'(ndone - d0), 32'd1);
    chk({nm, " writes"}, 32'(wlog.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < wlog.size(); i++) begin
      chk({nm, " code"}, 32'(wlog[base+i].code), 32'(exp_q[i]));
      chk({nm, " busy_at_write"}, 32'(wlog[base+i].busy), 32'd0);
      if (i > 0)
        chk({nm, " spacing_ok"},
            32'(wlog[base+i].cyc - wlog[base+i-1].cyc >= SPACING), 32'd1);
    end
    if (wlog.size() > base)
      chk({nm, " data_held"}, 32'(data), 32'(exp_q[exp_q.size()-1]));
  endtask

  typedef struct {
    string      nm;
    logic [7:0] sa;
    int         n;
    logic [5:0] last_code;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   base;
    int   t_w;
    int   t_d;
    int   d0;
    bit   ok;

    for (int i = 0; i < 256; i++) rom[i] = {1'b0, 6'(i)};
    rom[8'h10] = {1'b0, 6'h05};
    rom[8'h11] = {1'b0, 6'h13};
    rom[8'h12] = {1'b1, 6'h2D};
    rom[8'h00] = {1'b1, 6'h3F};
    rom[8'hFE] = {1'b0, 6'h21};
    rom[8'hFF] = {1'b0, 6'h22};

    vecs[0] = '{"three_entry", 8'h10, 3, 6'h2D};
    vecs[1] = '{"single", 8'h00, 1, 6'h3F};
    vecs[2] = '{"wrap", 8'hFE, 3, 6'h3F};
    vecs[3] = '{"max_len", 8'h80, 64, 6'h3F};

    tick();
    tick();
    chk("rst write", 32'(write), 32'd0);
    chk("rst data", 32'(data), 32'd0);
    chk("rst rom_addr", 32'(rom_addr), 32'd0);
    chk("rst active", 32'(active), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // latency with busy held low
    pulse_start(8'h00);
    chk("lat active", 32'(active), 32'd1);
    chk("lat rom_addr", 32'(rom_addr), 32'h00);
    t_w = -1;
    t_d = -1;
    for (int t = 0; t < 40 && t_d < 0; t++) begin
      if (write === 1'b1 && t_w < 0) t_w = t;
      if (done === 1'b1) t_d = t;
      if (t_d < 0) tick();
    end
    chk("lat write_cycle", 32'(t_w), 32'd3);
    chk("lat done_gap", 32'(t_d - t_w), 32'(1 + BUSY_GUARD));
    chk("lat data", 32'(data), 32'h3F);
    tick();
    chk("lat active_low", 32'(active), 32'd0);
    chk("lat done_pulse", 32'(done), 32'd0);

    chat_en = 1'b1;
    lmin = 2;
    lmax = 50;
    foreach (vecs[v]) begin
      model(vecs[v].sa);
      run_check(vecs[v].nm, vecs[v].sa, base);
      chk({vecs[v].nm, " table_n"}, 32'(wlog.size() - base),
          32'(vecs[v].n));
      chk({vecs[v].nm, " table_last"}, 32'(data),
          32'(vecs[v].last_code));
      repeat (60) tick();
    end

    // abort during second phoneme, with a stray start alongside
    lmin = 20;
    lmax = 50;
    base = wlog.size();
    d0   = ndone;
    pulse_start(8'h10);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (wlog.size() >= base + 2) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("abort second_write", 32'(ok), 32'd1);
    tick();
    abort      = 1'b1;
    start      = 1'b1;
    start_addr = 8'h00;
    tick();
    abort = 1'b0;
    start = 1'b0;
    repeat (120) tick();
    chk("abort writes", 32'(wlog.size() - base), 32'd2);
    chk("abort done_count", 32'(ndone - d0), 32'd1);
    chk("abort data", 32'(data), 32'h13);
    chk("abort active", 32'(active), 32'd0);

    // async reset while parked in WAIT_IDLE
    chat_en    = 1'b0;
    force_busy = 1'b1;
    pulse_start(8'h10);
    repeat (6) tick();
    base = wlog.size();
    #2 rst = 1'b1;
    #1;
    chk("arst write", 32'(write), 32'd0);
    chk("arst data", 32'(data), 32'd0);
    chk("arst rom_addr", 32'(rom_addr), 32'd0);
    chk("arst active", 32'(active), 32'd0);
    chk("arst done", 32'(done), 32'd0);
    tick();
    rst        = 1'b0;
    force_busy = 1'b0;
    repeat (30) tick();
    chk("arst no_write", 32'(wlog.size() - base), 32'd0);
    chk("arst idle", 32'(active), 32'd0);
    chat_en = 1'b1;
    lmin = 2;
    lmax = 20;
    model(8'h12);
    run_check("after_rst", 8'h12, base);
    repeat (30) tick();

    // randomized phrases
    for (int it = 0; it < 10; it++) begin
      logic [7:0] sa;
      for (int i = 0; i < 256; i++)
        rom[i] = {(it % 5 != 4) && ($urandom_range(0, 5) == 0),
                  6'($urandom_range(0, 63))};
      sa = 8'($urandom_range(0, 255));
      model(sa);
      run_check($sformatf("rand%0d", it), sa, base);
      repeat (30) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
